// File: rtl/gal_vec_sequencer_if.sv
`default_nettype none
// ============================================================================
// gal_vec_sequencer_if : host control, vector ROM, DUT pin and status bundle
// Revision: 1.0
// ============================================================================
interface gal_vec_sequencer_if #(
  parameter int ADDR_W = 10,
  parameter int ERR_W  = 16
) ();
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] last_addr;

  logic [ADDR_W-1:0] rom_addr;
  logic              rom_rd;
  logic [11:0]       rom_val;
  logic [11:0]       rom_dc;
  logic [19:0]       rom_exp;

  logic [11:0]       dut_i;
  logic [9:0]        dut_o;
  logic [9:0]        dut_oz;

  logic              busy;
  logic              done;
  logic              aborted;
  logic              vec_fail;
  logic [9:0]        fail_mask;
  logic [ERR_W-1:0]  err_cnt;
  logic [ADDR_W-1:0] first_fail;
  logic              any_fail;

  modport master (
    input  start, abort, last_addr, rom_val, rom_dc, rom_exp, dut_o, dut_oz,
    output rom_addr, rom_rd, dut_i, busy, done, aborted, vec_fail,
           fail_mask, err_cnt, first_fail, any_fail
  );

  modport slave (
    output start, abort, last_addr, rom_val, rom_dc, rom_exp, dut_o, dut_oz,
    input  rom_addr, rom_rd, dut_i, busy, done, aborted, vec_fail,
           fail_mask, err_cnt, first_fail, any_fail
  );
endinterface
`default_nettype wire

// File: rtl/gal_vec_sequencer.sv
`default_nettype none
// ============================================================================
// gal_vec_sequencer : ROM-driven vector apply / settle / compare engine
// Revision: 1.0
// ============================================================================
module gal_vec_sequencer #(
  parameter int SETTLE_CYC = 15,
  parameter int ADDR_W     = 10,
  parameter int ERR_W      = 16
) (
  input wire logic            clk,
  input wire logic            rst,
  gal_vec_sequencer_if.master bus
);

  localparam logic [7:0] c_SETTLE_LOAD = 8'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_SAMPLE = 3'd4,
    ST_FIN    = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [19:0]       exp_q, exp_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [11:0]       drv_q, drv_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic              anyf_q, anyf_d;
  logic              abrt_q, abrt_d;
  logic [9:0]        mask_q, mask_d;
  logic              vf_q, vf_d;
  logic [9:0]        mismatch;
  logic              in_run;

  // Per-output compare against the 2-bit expected code captured at LOAD
  always_comb begin
    mismatch = '0;
    for (int k = 0; k < 10; k++) begin
      case (exp_q[2*k +: 2])
        2'b00:   mismatch[k] = bus.dut_oz[k] | bus.dut_o[k];
        2'b01:   mismatch[k] = bus.dut_oz[k] | ~bus.dut_o[k];
        2'b10:   mismatch[k] = ~bus.dut_oz[k];
        default: mismatch[k] = 1'b0;
      endcase
    end
  end

  assign in_run = (state_q == ST_FETCH) || (state_q == ST_LOAD) ||
                  (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    last_d  = last_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    drv_d   = drv_q;
    err_d   = err_q;
    first_d = first_q;
    anyf_d  = anyf_q;
    abrt_d  = abrt_q;
    mask_d  = mask_q;
    vf_d    = 1'b0;

    // Abort wins over everything, including a compare in SAMPLE
    if (in_run && bus.abort) begin
      state_d = ST_FIN;
      abrt_d  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            last_d  = bus.last_addr;
            err_d   = '0;
            anyf_d  = 1'b0;
            first_d = '0;
            abrt_d  = 1'b0;
            mask_d  = '0;
            addr_d  = '0;
            state_d = ST_FETCH;
          end
        end
        ST_FETCH: state_d = ST_LOAD;
        ST_LOAD: begin
          drv_d   = bus.rom_val & ~bus.rom_dc;
          exp_d   = bus.rom_exp;
          cnt_d   = c_SETTLE_LOAD;
          state_d = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt_q == 8'd0) state_d = ST_SAMPLE;
          else               cnt_d   = cnt_q - 8'd1;
        end
        ST_SAMPLE: begin
          mask_d = mismatch;
          if (|mismatch) begin
            vf_d = 1'b1;
            if (err_q != {ERR_W{1'b1}}) err_d = err_q + 1'b1;
            if (!anyf_q) begin
              first_d = addr_q;
              anyf_d  = 1'b1;
            end
          end
          if (addr_q == last_q) begin
            state_d = ST_FIN;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = ST_FETCH;
          end
        end
        ST_FIN:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      last_q  <= '0;
      exp_q   <= '0;
      cnt_q   <= '0;
      drv_q   <= '0;
      err_q   <= '0;
      first_q <= '0;
      anyf_q  <= 1'b0;
      abrt_q  <= 1'b0;
      mask_q  <= '0;
      vf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
      drv_q   <= drv_d;
      err_q   <= err_d;
      first_q <= first_d;
      anyf_q  <= anyf_d;
      abrt_q  <= abrt_d;
      mask_q  <= mask_d;
      vf_q    <= vf_d;
    end
  end

  assign bus.rom_addr   = addr_q;
  assign bus.rom_rd     = (state_q == ST_FETCH);
  assign bus.dut_i      = drv_q;
  assign bus.busy       = in_run;
  assign bus.done       = (state_q == ST_FIN);
  assign bus.aborted    = abrt_q;
  assign bus.vec_fail   = vf_q;
  assign bus.fail_mask  = mask_q;
  assign bus.err_cnt    = err_q;
  assign bus.first_fail = first_q;
  assign bus.any_fail   = anyf_q;

endmodule
`default_nettype wire

// File: tb/tb_gal_vec_sequencer.sv
`default_nettype none
// ============================================================================
// tb_gal_vec_sequencer : directed + randomized checks against a vector-level model
// Revision: 1.0
// ============================================================================
module tb_gal_vec_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gal_vec_sequencer_if #(.ADDR_W(10), .ERR_W(16)) mb ();
  gal_vec_sequencer_if #(.ADDR_W(3),  .ERR_W(2))  sb ();

  gal_vec_sequencer #(.SETTLE_CYC(15), .ADDR_W(10), .ERR_W(16)) dut (
    .clk(clk), .rst(rst), .bus(mb)
  );
  gal_vec_sequencer #(.SETTLE_CYC(1), .ADDR_W(3), .ERR_W(2)) dut_s (
    .clk(clk), .rst(rst), .bus(sb)
  );

  // Vector ROM and DUT response tables shared by both sequencers
  logic [11:0] rv  [0:1023];
  logic [11:0] rd  [0:1023];
  logic [19:0] re  [0:1023];
  logic [9:0]  ro  [0:1023];
  logic [9:0]  roz [0:1023];

  always @(posedge clk) if (mb.rom_rd) begin
    mb.rom_val <= rv[mb.rom_addr];
    mb.rom_dc  <= rd[mb.rom_addr];
    mb.rom_exp <= re[mb.rom_addr];
  end
  always @(posedge clk) if (sb.rom_rd) begin
    sb.rom_val <= rv[{7'd0, sb.rom_addr}];
    sb.rom_dc  <= rd[{7'd0, sb.rom_addr}];
    sb.rom_exp <= re[{7'd0, sb.rom_addr}];
  end
  assign mb.dut_o  = ro[mb.rom_addr];
  assign mb.dut_oz = roz[mb.rom_addr];
  assign sb.dut_o  = ro[{7'd0, sb.rom_addr}];
  assign sb.dut_oz = roz[{7'd0, sb.rom_addr}];

  // Event monitors (only ever appended to; the stimulus works from snapshots)
  int          busy_cyc = 0, done_cnt = 0;
  logic [9:0]  obs_masks[$];
  int          s_busy_cyc = 0, s_done_cnt = 0, s_vf_cnt = 0;
  always @(negedge clk) begin
    if (mb.busy === 1'b1) busy_cyc++;
    if (mb.done === 1'b1) done_cnt++;
    if (mb.vec_fail === 1'b1) obs_masks.push_back(mb.fail_mask);
    if (sb.busy === 1'b1) s_busy_cyc++;
    if (sb.done === 1'b1) s_done_cnt++;
    if (sb.vec_fail === 1'b1) s_vf_cnt++;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pass/fail of each output pin from the L/H/Z/X rules
  function automatic logic [9:0] exp_mask(input logic [19:0] e, input logic [9:0] o,
                                          input logic [9:0] oz);
    logic [9:0] m;
    m = '0;
    for (int k = 0; k < 10; k++) begin
      int code;
      bit ok;
      code = int'((e >> (2 * k)) & 20'h3);
      if (code == 3)      ok = 1'b1;
      else if (code == 2) ok = (oz[k] == 1'b1);
      else                ok = (oz[k] == 1'b0) && (int'(o[k]) == code);
      m[k] = !ok;
    end
    return m;
  endfunction

  // pass_all=1 builds responses that satisfy every expected code
  task automatic fill(input bit pass_all);
    for (int a = 0; a < 1024; a++) begin
      rv[a]  = 12'($urandom);
      rd[a]  = 12'($urandom);
      re[a]  = 20'($urandom);
      ro[a]  = 10'($urandom);
      roz[a] = 10'($urandom);
      if (pass_all) begin
        for (int k = 0; k < 10; k++) begin
          case (re[a][2*k +: 2])
            2'b00:   begin ro[a][k] = 1'b0; roz[a][k] = 1'b0; end
            2'b01:   begin ro[a][k] = 1'b1; roz[a][k] = 1'b0; end
            2'b10:   roz[a][k] = 1'b1;
            default: ;
          endcase
        end
      end
    end
  endtask

  task automatic run_check(input int L, input string tag);
    logic [9:0] q[$];
    logic [9:0] m;
    int nf, ff, t, b_busy, b_done, b_idx;
    bit af;
    nf = 0; ff = 0; af = 1'b0;
    for (int a = 0; a <= L; a++) begin
      m = exp_mask(re[a], ro[a], roz[a]);
      if (m != 10'd0) begin
        q.push_back(m);
        if (!af) begin af = 1'b1; ff = a; end
        nf++;
      end
    end
    b_busy = busy_cyc; b_done = done_cnt; b_idx = obs_masks.size();
    mb.last_addr = 10'(L); mb.start = 1'b1;
    step();
    mb.start = 1'b0; mb.last_addr = '0;
    chk({tag, ".busy_on"},   32'(mb.busy), 32'd1);
    chk({tag, ".rom_rd"},    32'(mb.rom_rd), 32'd1);
    chk({tag, ".clr_err"},   32'(mb.err_cnt), 32'd0);
    chk({tag, ".clr_abrt"},  32'(mb.aborted), 32'd0);
    chk({tag, ".clr_mask"},  32'(mb.fail_mask), 32'd0);
    step(2);
    chk({tag, ".dut_i_load"}, 32'(mb.dut_i), 32'(rv[0] & ~rd[0]));
    t = 0;
    while (mb.done !== 1'b1 && t < (L + 1) * 18 + 10) begin step(); t++; end
    chk({tag, ".done_seen"}, 32'(mb.done), 32'd1);
    chk({tag, ".busy_off"},  32'(mb.busy), 32'd0);
    step(2);
    chk({tag, ".busy_cyc"},  32'(busy_cyc - b_busy), 32'((L + 1) * 18));
    chk({tag, ".done_cnt"},  32'(done_cnt - b_done), 32'd1);
    chk({tag, ".vf_cnt"},    32'(obs_masks.size() - b_idx), 32'(q.size()));
    for (int i = 0; i < q.size(); i++)
      if (b_idx + i < obs_masks.size())
        chk({tag, ".mask"}, 32'(obs_masks[b_idx + i]), 32'(q[i]));
    chk({tag, ".err_cnt"},   32'(mb.err_cnt), 32'(nf));
    chk({tag, ".first"},     32'(mb.first_fail), 32'(ff));
    chk({tag, ".any"},       32'(mb.any_fail), 32'(af));
    chk({tag, ".aborted"},   32'(mb.aborted), 32'd0);
    chk({tag, ".dut_i_end"}, 32'(mb.dut_i), 32'(rv[L] & ~rd[L]));
    chk({tag, ".addr_end"},  32'(mb.rom_addr), 32'(L));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, nf, ff, s_b, s_d, s_v, b_done, b_idx;
    bit af;
    mb.start = 1'b0; mb.abort = 1'b0; mb.last_addr = '0;
    sb.start = 1'b0; sb.abort = 1'b0; sb.last_addr = '0;
    fill(1'b1);
    step(3);
    chk("rst.busy",  32'(mb.busy), 32'd0);
    chk("rst.done",  32'(mb.done), 32'd0);
    chk("rst.dut_i", 32'(mb.dut_i), 32'd0);
    chk("rst.addr",  32'(mb.rom_addr), 32'd0);
    chk("rst.err",   32'(mb.err_cnt), 32'd0);
    chk("rst.first", 32'(mb.first_fail), 32'd0);
    chk("rst.flags", 32'({mb.any_fail, mb.aborted, mb.vec_fail, mb.rom_rd}), 32'd0);
    chk("rst.mask",  32'(mb.fail_mask), 32'd0);
    rst = 1'b0;
    step(2);

    fill(1'b1);
    run_check(2, "pass3");

    fill(1'b1);
    re[1][7:6] = 2'b01; ro[1][3] = 1'b0; roz[1][3] = 1'b0;
    run_check(3, "h_vs_l");
    chk("h_vs_l.mask_const", 32'(obs_masks[obs_masks.size() - 1]), 32'h008);
    chk("h_vs_l.first_const", 32'(mb.first_fail), 32'd1);

    fill(1'b1);
    re[0][1:0] = 2'b10; roz[0][0] = 1'b0;
    run_check(0, "z_fail");
    chk("z_fail.mask_hold", 32'(mb.fail_mask), 32'h001);

    fill(1'b0);
    for (int a = 0; a < 4; a++) re[a] = 20'hFFFFF;
    run_check(3, "x_all");

    fill(1'b1);
    rv[0] = 12'hFFF; rd[0] = 12'h0F0;
    run_check(0, "dc_mask");
    chk("dc_mask.const", 32'(mb.dut_i), 32'hF0F);

    mb.abort = 1'b1; step(); mb.abort = 1'b0; step();
    chk("idle_abort.aborted", 32'(mb.aborted), 32'd0);
    chk("idle_abort.busy",    32'(mb.busy), 32'd0);

    repeat (4) begin
      fill(1'b0);
      run_check(int'($urandom_range(1, 12)), "rand");
    end

    // Abort mid-SETTLE of vector 2; vector 0 fails, vector 2 would have
    fill(1'b1);
    re[0][1:0] = 2'b01; ro[0][0] = 1'b0; roz[0][0] = 1'b0;
    re[2][1:0] = 2'b01; ro[2][0] = 1'b0; roz[2][0] = 1'b0;
    b_done = done_cnt; b_idx = obs_masks.size();
    mb.last_addr = 10'd3; mb.start = 1'b1; step(); mb.start = 1'b0;
    step(40);
    chk("abort.addr", 32'(mb.rom_addr), 32'd2);
    mb.abort = 1'b1; step(); mb.abort = 1'b0;
    chk("abort.done",    32'(mb.done), 32'd1);
    chk("abort.aborted", 32'(mb.aborted), 32'd1);
    chk("abort.busy",    32'(mb.busy), 32'd0);
    chk("abort.err",     32'(mb.err_cnt), 32'd1);
    chk("abort.first",   32'(mb.first_fail), 32'd0);
    mb.start = 1'b1; step(); mb.start = 1'b0;
    chk("fin_start.busy",    32'(mb.busy), 32'd0);
    chk("fin_start.aborted", 32'(mb.aborted), 32'd1);
    step();
    chk("abort.done_cnt", 32'(done_cnt - b_done), 32'd1);
    chk("abort.vf_cnt",   32'(obs_masks.size() - b_idx), 32'd1);
    fill(1'b1);
    run_check(1, "after_abort");

    // Reset during SETTLE of vector 1
    fill(1'b1);
    re[0][1:0] = 2'b01; ro[0][0] = 1'b0; roz[0][0] = 1'b0;
    rv[1] = 12'hABC; rd[1] = 12'h000;
    mb.last_addr = 10'd3; mb.start = 1'b1; step(); mb.start = 1'b0;
    step(25);
    chk("pre_rst.dut_i", 32'(mb.dut_i), 32'hABC);
    chk("pre_rst.err",   32'(mb.err_cnt), 32'd1);
    b_done = done_cnt;
    rst = 1'b1; #1;
    chk("mid_rst.busy",  32'(mb.busy), 32'd0);
    chk("mid_rst.dut_i", 32'(mb.dut_i), 32'd0);
    chk("mid_rst.addr",  32'(mb.rom_addr), 32'd0);
    chk("mid_rst.err",   32'(mb.err_cnt), 32'd0);
    chk("mid_rst.flags", 32'({mb.any_fail, mb.aborted, mb.vec_fail, mb.done}), 32'd0);
    step(3); rst = 1'b0; step(3);
    chk("mid_rst.no_done", 32'(done_cnt - b_done), 32'd0);
    chk("mid_rst.idle",    32'(mb.busy), 32'd0);
    fill(1'b0);
    run_check(2, "post_rst");

    // Narrow instance: 8 vectors to the top address, 5 failures, 2-bit counter
    fill(1'b0);
    for (int a = 0; a < 8; a++) begin
      if (a == 0 || a == 1 || a == 3 || a == 5 || a == 6) begin
        re[a] = 20'h00000; roz[a] = 10'h3FF;
      end else begin
        re[a] = 20'hFFFFF;
      end
    end
    nf = 0; ff = 0; af = 1'b0;
    for (int a = 0; a < 8; a++)
      if (exp_mask(re[a], ro[a], roz[a]) != 10'd0) begin
        if (!af) begin af = 1'b1; ff = a; end
        nf++;
      end
    s_b = s_busy_cyc; s_d = s_done_cnt; s_v = s_vf_cnt;
    sb.last_addr = 3'd7; sb.start = 1'b1; step(); sb.start = 1'b0;
    chk("sat.busy_on", 32'(sb.busy), 32'd1);
    t = 0;
    while (sb.done !== 1'b1 && t < 60) begin step(); t++; end
    chk("sat.done_seen", 32'(sb.done), 32'd1);
    step(2);
    chk("sat.busy_cyc", 32'(s_busy_cyc - s_b), 32'd32);
    chk("sat.done_cnt", 32'(s_done_cnt - s_d), 32'd1);
    chk("sat.vf_cnt",   32'(s_vf_cnt - s_v), 32'(nf));
    chk("sat.err_cnt",  32'(sb.err_cnt), 32'((nf > 3) ? 3 : nf));
    chk("sat.first",    32'(sb.first_fail), 32'(ff));
    chk("sat.any",      32'(sb.any_fail), 32'(af));
    chk("sat.addr_end", 32'(sb.rom_addr), 32'd7);
    chk("sat.busy_off", 32'(sb.busy), 32'd0);
    chk("sat.dut_i",    32'(sb.dut_i), 32'(rv[7] & ~rd[7]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
